// File: rtl/router_inport.sv
// Ingress buffer for one router lane: registers link beats, checks SOF/EOF framing, queues them in a FIFO.
// Beats reach D two edges after sampling at minimum; D_BP stalls the pop stage, and I_BP rises SKID entries before full.
module router_inport #(
    parameter int AW       = 4,
    parameter int SKID     = 4,
    parameter int DEST_LSB = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [63:0]   I,
    input  logic          I_HDR_VALID,
    input  logic          I_PLD_VALID,
    input  logic          I_SOF,
    input  logic          I_EOF,
    output logic          I_BP,
    output logic [63:0]   D,
    output logic [7:0]    DEST,
    output logic          DEST_VALID,
    output logic          D_HDR_VALID,
    output logic          D_PLD_VALID,
    output logic          D_SOF,
    output logic          D_EOF,
    input  logic          D_BP,
    output logic [AW:0]   LEVEL,
    output logic          OVF,
    output logic          FRAME_ERR
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] BP_LVL   = (AW+1)'(DEPTH - SKID);

    typedef struct packed {
        logic [63:0] dat;
        logic        hdr;
        logic        pld;
        logic        sof;
        logic        eof;
    } beat_t;

    typedef enum logic {IDLE, FRAME} state_t;

    beat_t          in_q;
    logic           in_vld_q;
    state_t         state_q, state_d;
    logic           accept, bad_beat;
    logic           full, wr_en, pop;
    beat_t          mem_q [DEPTH];
    beat_t          rd_beat;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q, level_d;
    logic           ovf_q, frame_err_q;
    beat_t          out_q, out_d;
    logic [7:0]     dest_q, dest_d;
    logic           dest_vld_q, dest_vld_d;

    // Input register: framing decisions are made on the registered beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_q     <= '0;
            in_vld_q <= 1'b0;
        end else begin
            in_q.dat <= I;
            in_q.hdr <= I_HDR_VALID;
            in_q.pld <= I_PLD_VALID;
            in_q.sof <= I_SOF;
            in_q.eof <= I_EOF;
            in_vld_q <= I_HDR_VALID | I_PLD_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        bad_beat = 1'b0;
        if (in_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (in_q.sof) begin
                        accept = 1'b1;
                        if (!in_q.eof) state_d = FRAME;
                    end else begin
                        bad_beat = 1'b1;
                    end
                end
                FRAME: begin
                    if (!in_q.sof) begin
                        accept = 1'b1;
                        if (in_q.eof) state_d = IDLE;
                    end else begin
                        bad_beat = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Full comes from the registered level, so a same-cycle pop never frees room for the write.
    assign full    = (level_q == FULL_LVL);
    assign wr_en   = accept & ~full;
    assign pop     = (level_q != '0) & ~D_BP;
    assign rd_beat = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q     <= level_d;
            frame_err_q <= bad_beat;
            if (accept && full) ovf_q <= 1'b1;
        end
    end

    // DEST_VALID drops the cycle after EOF is shown unless a new SOF replaces it.
    always_comb begin
        out_d      = out_q;
        out_d.hdr  = 1'b0;
        out_d.pld  = 1'b0;
        out_d.sof  = 1'b0;
        out_d.eof  = 1'b0;
        dest_d     = dest_q;
        dest_vld_d = dest_vld_q;
        if (out_q.eof) dest_vld_d = 1'b0;
        if (pop) begin
            out_d = rd_beat;
            if (rd_beat.sof) begin
                dest_d     = rd_beat.dat[DEST_LSB +: 8];
                dest_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q      <= '0;
            dest_q     <= '0;
            dest_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            dest_q     <= dest_d;
            dest_vld_q <= dest_vld_d;
        end
    end

    assign I_BP        = (level_q >= BP_LVL);
    assign D           = out_q.dat;
    assign D_HDR_VALID = out_q.hdr;
    assign D_PLD_VALID = out_q.pld;
    assign D_SOF       = out_q.sof;
    assign D_EOF       = out_q.eof;
    assign DEST        = dest_q;
    assign DEST_VALID  = dest_vld_q;
    assign LEVEL       = level_q;
    assign OVF         = ovf_q;
    assign FRAME_ERR   = frame_err_q;

endmodule
